// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate data cache
// for an 8-bit byte-addressed CPU backed by a 32-bit block memory.
//
// Parameters:
//   LINES          number of lines (power of 2, 2..16); IW=log2(LINES), tag 6-IW bits
// Ports:
//   CLK            system clock, rising edge
//   RESET          asynchronous active-low reset
//   READ/WRITE     CPU byte request, held until BUSYWAIT low (both high = write)
//   ADDRESS[7:0]   {tag, index, offset[1:0]}
//   WRITEDATA[7:0] CPU store byte
//   BUSYWAIT       CPU stall
//   WORD1..WORD4   bytes 0..3 of the indexed block (to downstream byte selector)
//   OFFSET[1:0]    ADDRESS[1:0], select for the downstream byte selector
//   MEM_READ/MEM_WRITE, MEM_ADDRESS[5:0], MEM_WRITEDATA[31:0]  block memory request
//   MEM_READDATA[31:0], MEM_BUSYWAIT                          block memory response
// Optional feature (macro DCACHE_STATS_EN):
//   HIT_COUNT/MISS_COUNT[15:0]  saturating hit / miss counters
module dcache_controller #(
  parameter int unsigned LINES = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        READ,
  input  logic        WRITE,
  input  logic [7:0]  ADDRESS,
  input  logic [7:0]  WRITEDATA,
  output logic        BUSYWAIT,
  output logic [7:0]  WORD1,
  output logic [7:0]  WORD2,
  output logic [7:0]  WORD3,
  output logic [7:0]  WORD4,
  output logic [1:0]  OFFSET,
  output logic        MEM_READ,
  output logic        MEM_WRITE,
  output logic [5:0]  MEM_ADDRESS,
  output logic [31:0] MEM_WRITEDATA,
  input  logic [31:0] MEM_READDATA,
  input  logic        MEM_BUSYWAIT
`ifdef DCACHE_STATS_EN
  ,
  output logic [15:0] HIT_COUNT,
  output logic [15:0] MISS_COUNT
`endif
);

  localparam int unsigned IW = $clog2(LINES);
  localparam int unsigned TW = 6 - IW;

  typedef enum logic [1:0] {IDLE, WRITEBACK, FETCH, UPDATE} state_t;

  state_t state, next;

  logic [31:0]      blocks [LINES];
  logic [TW-1:0]    tags   [LINES];
  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [31:0]      fill_q;

  logic [IW-1:0] idx;
  logic [TW-1:0] atag;
  logic          req;
  logic          hit;
  logic          busy;

  assign idx  = ADDRESS[IW+1:2];
  assign atag = ADDRESS[7:IW+2];
  assign req  = READ | WRITE;
  assign hit  = valid[idx] && (tags[idx] == atag);

  assign WORD1  = blocks[idx][7:0];
  assign WORD2  = blocks[idx][15:8];
  assign WORD3  = blocks[idx][23:16];
  assign WORD4  = blocks[idx][31:24];
  assign OFFSET = ADDRESS[1:0];

  // Stall is masked while reset is held so a CPU parked on a request
  // is not reported as stalled by a cache that is not running.
  assign BUSYWAIT = busy & RESET;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= IDLE;
    else        state <= next;
  end

  // Memory request outputs decode from state, so an asynchronous reset
  // drops them in the same instant the state returns to IDLE.
  always_comb begin
    next          = state;
    busy          = 1'b0;
    MEM_READ      = 1'b0;
    MEM_WRITE     = 1'b0;
    MEM_ADDRESS   = '0;
    MEM_WRITEDATA = '0;
    case (state)
      IDLE: begin
        if (req && !hit) begin
          busy = 1'b1;
          next = (valid[idx] && dirty[idx]) ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        busy          = 1'b1;
        MEM_WRITE     = 1'b1;
        MEM_ADDRESS   = {tags[idx], idx};
        MEM_WRITEDATA = blocks[idx];
        if (!MEM_BUSYWAIT) next = FETCH;
      end
      FETCH: begin
        busy        = 1'b1;
        MEM_READ    = 1'b1;
        MEM_ADDRESS = {atag, idx};
        if (!MEM_BUSYWAIT) next = UPDATE;
      end
      UPDATE: begin
        busy = 1'b1;
        next = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int unsigned i = 0; i < LINES; i++) begin
        blocks[i] <= '0;
        tags[i]   <= '0;
      end
      valid  <= '0;
      dirty  <= '0;
      fill_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          // WRITE alone decides a store, so READ+WRITE behaves as a write.
          if (WRITE && hit) begin
            blocks[idx][{ADDRESS[1:0], 3'b000} +: 8] <= WRITEDATA;
            dirty[idx] <= 1'b1;
          end
        end
        FETCH: begin
          if (!MEM_BUSYWAIT) fill_q <= MEM_READDATA;
        end
        UPDATE: begin
          blocks[idx] <= fill_q;
          tags[idx]   <= atag;
          valid[idx]  <= 1'b1;
          dirty[idx]  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  // miss_seen marks that the current request already missed, so its
  // completion after the refill is not also counted as a hit.
  logic miss_seen;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      HIT_COUNT  <= '0;
      MISS_COUNT <= '0;
      miss_seen  <= 1'b0;
    end else if (state == IDLE) begin
      if (req && !hit) begin
        if (MISS_COUNT != 16'hFFFF) MISS_COUNT <= MISS_COUNT + 16'd1;
        miss_seen <= 1'b1;
      end else if (req && hit) begin
        if (!miss_seen && (HIT_COUNT != 16'hFFFF)) HIT_COUNT <= HIT_COUNT + 16'd1;
        miss_seen <= 1'b0;
      end else begin
        miss_seen <= 1'b0;
      end
    end
  end
`endif

endmodule
